pid_multi: RTL and testbench

//   Time-multiplexed N-channel fixed-point PID controller: one shared Qm.Q_BITS multiplier, per-channel gains and state.

---
 rtl/pid_multi.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_pid_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pid_multi.sv
// Time-multiplexed N-channel fixed-point PID with one shared saturating multiplier.
// Optional derivative path is compiled in when the PID_DERIV_EN macro is defined.
module pid_multi #(
    parameter int D_WIDTH = 16,
    parameter int Q_BITS  = 13,
    parameter int N_CH    = 4,
    parameter int LIM_MAX = 1 << 12,
    parameter int LIM_MIN = -(1 << 12),
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [1:0]                cfg_addr,
    input  logic signed [D_WIDTH-1:0] cfg_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH_W-1:0]           in_ch,
    input  logic signed [D_WIDTH-1:0] target,
    input  logic signed [D_WIDTH-1:0] measurement,
    output logic                      out_valid,
    output logic [CH_W-1:0]           out_ch,
    output logic signed [D_WIDTH-1:0] out,
    output logic                      out_sat
);

    localparam int unsigned PW     = 2 * D_WIDTH;
    localparam int unsigned EW     = D_WIDTH + 1;
    localparam int unsigned SW     = D_WIDTH + 2;
    localparam int unsigned N_CH_U = N_CH;

    localparam logic signed [D_WIDTH-1:0] D_MAX  = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [D_WIDTH-1:0] D_MIN  = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]      LIM_HI = SW'(LIM_MAX);
    localparam logic signed [SW-1:0]      LIM_LO = SW'(LIM_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_P,
        S_I,
`ifdef PID_DERIV_EN
        S_D,
`endif
        S_SUM
    } state_t;

    // Saturate a wide signed value into the data width.
    function automatic logic signed [D_WIDTH-1:0] sat_d(input logic signed [PW-1:0] x);
        if (x > PW'(D_MAX)) begin
            return D_MAX;
        end else if (x < PW'(D_MIN)) begin
            return D_MIN;
        end
        return D_WIDTH'(x);
    endfunction

    // Clamp into the output/integrator window.
    function automatic logic signed [SW-1:0] clamp_lim(input logic signed [SW-1:0] x);
        if (x > LIM_HI) begin
            return LIM_HI;
        end else if (x < LIM_LO) begin
            return LIM_LO;
        end
        return x;
    endfunction

    state_t state, state_nxt;

    logic cfg_en, accept, ld_err, ld_p, ld_i, done;
`ifdef PID_DERIV_EN
    logic ld_d;
`endif

    logic signed [D_WIDTH-1:0] kp    [N_CH];
    logic signed [D_WIDTH-1:0] ki    [N_CH];
    logic signed [D_WIDTH-1:0] integ [N_CH];
`ifdef PID_DERIV_EN
    logic signed [D_WIDTH-1:0] kd       [N_CH];
    logic signed [D_WIDTH-1:0] prev_err [N_CH];
`endif

    logic [CH_W-1:0]           ch_q;
    logic signed [D_WIDTH-1:0] tgt_q, meas_q, err_q, p_q, inew_q;
`ifdef PID_DERIV_EN
    logic signed [D_WIDTH-1:0] d_q;
`endif

    logic [CH_W-1:0]           ch_in_c;
    logic                      cfg_ch_ok;
    logic signed [EW-1:0]      err_wide;
    logic signed [D_WIDTH-1:0] err_c;
    logic signed [D_WIDTH-1:0] mul_a, mul_b, mul_res;
    logic signed [PW-1:0]      prod;
    logic signed [EW-1:0]      integ_sum;
    logic signed [D_WIDTH-1:0] inew_c;
    logic signed [D_WIDTH-1:0] d_val;
    logic signed [SW-1:0]      sum_c;
    logic signed [D_WIDTH-1:0] out_c;
    logic                      sat_hi, sat_lo, keep_integ;
`ifdef PID_DERIV_EN
    logic signed [EW-1:0]      diff_wide;
    logic signed [D_WIDTH-1:0] diff_c;
`endif

    // Out-of-range request channels alias to channel 0; out-of-range cfg writes are dropped.
    assign ch_in_c   = (32'(in_ch) < N_CH_U) ? in_ch : '0;
    assign cfg_ch_ok = (32'(cfg_ch) < N_CH_U);

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a cfg strobe in IDLE blocks acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid && !cfg_we) state_nxt = S_ERR;
            S_ERR:  state_nxt = S_P;
            S_P:    state_nxt = S_I;
`ifdef PID_DERIV_EN
            S_I:    state_nxt = S_D;
            S_D:    state_nxt = S_SUM;
`else
            S_I:    state_nxt = S_SUM;
`endif
            S_SUM:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        in_ready = 1'b0;
        cfg_en   = 1'b0;
        accept   = 1'b0;
        ld_err   = 1'b0;
        ld_p     = 1'b0;
        ld_i     = 1'b0;
        done     = 1'b0;
`ifdef PID_DERIV_EN
        ld_d     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                in_ready = !cfg_we;
                cfg_en   = cfg_we && cfg_ch_ok;
                accept   = in_valid && !cfg_we;
            end
            S_ERR:  ld_err = 1'b1;
            S_P:    ld_p   = 1'b1;
            S_I:    ld_i   = 1'b1;
`ifdef PID_DERIV_EN
            S_D:    ld_d   = 1'b1;
`endif
            S_SUM:  done   = 1'b1;
            default: ;
        endcase
    end

    assign err_wide = EW'(tgt_q) - EW'(meas_q);
    assign err_c    = sat_d(PW'(err_wide));

`ifdef PID_DERIV_EN
    assign diff_wide = EW'(err_q) - EW'(prev_err[ch_q]);
    assign diff_c    = sat_d(PW'(diff_wide));
`endif

    // Shared multiplier operand select.
    always_comb begin
        mul_a = kp[ch_q];
        mul_b = err_q;
        case (state)
            S_I: mul_a = ki[ch_q];
`ifdef PID_DERIV_EN
            S_D: begin
                mul_a = kd[ch_q];
                mul_b = diff_c;
            end
`endif
            default: ;
        endcase
    end

    assign prod    = PW'(mul_a) * PW'(mul_b);
    assign mul_res = sat_d(prod >>> Q_BITS);

    assign integ_sum = EW'(integ[ch_q]) + EW'(mul_res);
    assign inew_c    = D_WIDTH'(clamp_lim(SW'(integ_sum)));

`ifdef PID_DERIV_EN
    assign d_val = d_q;
`else
    assign d_val = '0;
`endif

    // Final sum, clamp and conditional-integration decision.
    assign sum_c      = SW'(p_q) + SW'(inew_q) + SW'(d_val);
    assign out_c      = D_WIDTH'(clamp_lim(sum_c));
    assign sat_hi     = (sum_c > LIM_HI);
    assign sat_lo     = (sum_c < LIM_LO);
    assign keep_integ = !((sat_hi && (inew_q > integ[ch_q])) ||
                          (sat_lo && (inew_q < integ[ch_q])));

    // Iteration pipeline registers and result port.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ch_q      <= '0;
            tgt_q     <= '0;
            meas_q    <= '0;
            err_q     <= '0;
            p_q       <= '0;
            inew_q    <= '0;
`ifdef PID_DERIV_EN
            d_q       <= '0;
`endif
            out_valid <= 1'b0;
            out_ch    <= '0;
            out       <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                ch_q   <= ch_in_c;
                tgt_q  <= target;
                meas_q <= measurement;
            end
            if (ld_err) err_q  <= err_c;
            if (ld_p)   p_q    <= mul_res;
            if (ld_i)   inew_q <= inew_c;
`ifdef PID_DERIV_EN
            if (ld_d)   d_q    <= mul_res;
`endif
            out_valid <= done;
            if (done) begin
                out     <= out_c;
                out_sat <= sat_hi || sat_lo;
                out_ch  <= ch_q;
            end
        end
    end

    // Gain registers, written by the host only while idle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < N_CH; i++) begin
                kp[i] <= '0;
                ki[i] <= '0;
`ifdef PID_DERIV_EN
                kd[i] <= '0;
`endif
            end
        end else if (cfg_en) begin
            case (cfg_addr)
                2'd0: kp[cfg_ch] <= cfg_data;
                2'd1: ki[cfg_ch] <= cfg_data;
`ifdef PID_DERIV_EN
                2'd2: kd[cfg_ch] <= cfg_data;
`endif
                default: ;
            endcase
        end
    end

    // Per-channel controller state: updated at SUM, cleared by cfg address 3.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < N_CH; i++) begin
                integ[i] <= '0;
`ifdef PID_DERIV_EN
                prev_err[i] <= '0;
`endif
            end
        end else begin
            if (done) begin
`ifdef PID_DERIV_EN
                prev_err[ch_q] <= err_q;
`endif
                if (keep_integ) integ[ch_q] <= inew_q;
            end
            if (cfg_en && (cfg_addr == 2'd3)) begin
                integ[cfg_ch] <= '0;
`ifdef PID_DERIV_EN
                prev_err[cfg_ch] <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pid_multi.sv
// Bench for pid_multi: vector table driven through a scoreboard, plus handshake/reset sequences.
module tb_pid_multi;

    localparam int CH_W = 2;
`ifdef PID_DERIV_EN
    localparam int LAT = 5;
    localparam int DEN = 1;
`else
    localparam int LAT = 4;
    localparam int DEN = 0;
`endif
    localparam int OP_CFG = 0;
    localparam int OP_IT  = 1;

    logic               clk = 1'b0;
    logic               rstb = 1'b0;
    logic               cfg_we = 1'b0;
    logic [CH_W-1:0]    cfg_ch = '0;
    logic [1:0]         cfg_addr = '0;
    logic signed [15:0] cfg_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [CH_W-1:0]    in_ch = '0;
    logic signed [15:0] target = '0;
    logic signed [15:0] measurement = '0;
    logic               out_valid;
    logic [CH_W-1:0]    out_ch;
    logic signed [15:0] out;
    logic               out_sat;

    pid_multi dut (
        .clk(clk), .rstb(rstb),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .target(target), .measurement(measurement),
        .out_valid(out_valid), .out_ch(out_ch), .out(out), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct { int op; int ch; int a; int b; int exp_out; int exp_sat; } vec_t;
    typedef struct { int ch; int out_v; int sat; int acc; } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: every out_valid pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rstb && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got pulse out=%0d, expected none", out);
            end else begin
                mon_e = sb.pop_front();
                chk("out", int'(out), mon_e.out_v);
                chk("out_sat", int'(out_sat), mon_e.sat);
                chk("out_ch", int'(out_ch), mon_e.ch);
                chk("latency", cyc - mon_e.acc, LAT);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic cfg(input int ch, input int addr, input int data);
        wait_idle();
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_addr = 2'(addr);
        cfg_data = 16'(data);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic iterate(input int ch, input int tgt, input int meas, input int eo, input int es,
                           input bit push, input bit keep, output int stalls);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        in_ch       = CH_W'(ch);
        target      = 16'(tgt);
        measurement = 16'(meas);
        in_valid    = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        stalls = n;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=0, expected 1");
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.ch = ch; e.out_v = eo; e.sat = es; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int pulses;

        // T1 proportional
        vt.push_back('{OP_CFG, 0, 0, 8192, 0, 0});
        vt.push_back('{OP_IT,  0, 1000, 0, 1000, 0});
        // T2 integral accumulation and clear
        vt.push_back('{OP_CFG, 1, 1, 4096, 0, 0});
        vt.push_back('{OP_IT,  1, 1000, 0, 500, 0});
        vt.push_back('{OP_IT,  1, 1000, 0, 1000, 0});
        vt.push_back('{OP_IT,  1, 1000, 0, 1500, 0});
        vt.push_back('{OP_CFG, 1, 3, 0, 0, 0});
        vt.push_back('{OP_IT,  1, 1000, 0, 500, 0});
        // T3 saturation both ways with anti-windup
        vt.push_back('{OP_CFG, 2, 0, 8192, 0, 0});
        vt.push_back('{OP_CFG, 2, 1, 8192, 0, 0});
        vt.push_back('{OP_IT,  2, 20000, -20000, 4096, 1});
        vt.push_back('{OP_IT,  2, -500, 0, -1000, 0});
        vt.push_back('{OP_IT,  2, -20000, 20000, -4096, 1});
        vt.push_back('{OP_IT,  2, 0, 0, -500, 0});
        // T4 derivative (kd write ignored when the D path is absent)
        vt.push_back('{OP_CFG, 3, 2, 8192, 0, 0});
        vt.push_back('{OP_IT,  3, 100, 0, 100 * DEN, 0});
        vt.push_back('{OP_IT,  3, 300, 0, 200 * DEN, 0});
        // T5 channel isolation
        vt.push_back('{OP_CFG, 0, 1, 8192, 0, 0});
        vt.push_back('{OP_IT,  0, 100, 0, 200, 0});
        vt.push_back('{OP_IT,  1, 0, 0, 500, 0});
        vt.push_back('{OP_IT,  0, 100, 0, 300, 0});

        repeat (3) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk("rst_out", int'(out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        foreach (vt[i]) begin
            if (vt[i].op == OP_CFG) cfg(vt[i].ch, vt[i].a, vt[i].b);
            else iterate(vt[i].ch, vt[i].a, vt[i].b, vt[i].exp_out, vt[i].exp_sat, 1'b1, 1'b0, st);
        end
        wait_idle();

        // cfg_we in IDLE takes priority over a pending request
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 2'd0; cfg_data = 16'sd8192;
        in_ch = 2'd0; target = 16'sd100; measurement = 16'sd0; in_valid = 1'b1;
        #1 chk("cfg_prio_in_ready", int'(in_ready), 0);
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        #1 chk("idle_in_ready", int'(in_ready), 1);

        // back-to-back requests stall for the full iteration
        iterate(0, 100, 0, 400, 0, 1'b1, 1'b1, st);
        iterate(0, 100, 0, 500, 0, 1'b1, 1'b0, st);
        chk("stall_cycles", st, LAT);
        wait_idle();

        // cfg write while busy is dropped
        iterate(1, 1000, 0, 1000, 0, 1'b1, 1'b0, st);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_addr = 2'd1; cfg_data = 16'sd0;
        chk("busy_in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        cfg_we = 1'b0;
        iterate(1, 1000, 0, 1500, 0, 1'b1, 1'b0, st);
        wait_idle();

        // reset at edge 2 aborts the iteration and clears gains/state
        iterate(0, 1000, 0, 0, 0, 1'b0, 1'b0, st);
        @(posedge clk);
        @(posedge clk);
        #1 rstb = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort_no_out_valid", pulses, 0);
        chk("post_rst_out", int'(out), 0);
        chk("post_rst_out_ch", int'(out_ch), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);
        iterate(0, 1000, 0, 0, 0, 1'b1, 1'b0, st);
        iterate(1, 1000, 0, 0, 0, 1'b1, 1'b0, st);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
